// File: rtl/shift_reg_pkg.sv
// Shared definitions for the sequenced shift register: operation codes,
// FSM state encoding and a helper to classify shift/rotate operations.
package shift_reg_pkg;

  localparam logic [2:0] MODE_HOLD  = 3'b000;
  localparam logic [2:0] MODE_LOAD  = 3'b001;
  localparam logic [2:0] MODE_SHL   = 3'b010;
  localparam logic [2:0] MODE_SHR   = 3'b011;
  localparam logic [2:0] MODE_ROTL  = 3'b100;
  localparam logic [2:0] MODE_ROTR  = 3'b101;
  localparam logic [2:0] MODE_CLEAR = 3'b110;
  localparam logic [2:0] MODE_HOLD2 = 3'b111;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // True for the four operations that move bits one position per step.
  function automatic logic is_shift_mode(input logic [2:0] m);
    return (m == MODE_SHL) || (m == MODE_SHR) ||
           (m == MODE_ROTL) || (m == MODE_ROTR);
  endfunction

endpackage

// File: rtl/shift_step.sv
// Single-bit shifter/rotator. Purely combinational; non-shift modes pass
// the register through and report no expelled bit.
module shift_step
  import shift_reg_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] q_i,
  input  logic [2:0]       mode_i,
  input  logic             sin_i,
  output logic [WIDTH-1:0] q_o,
  output logic             expel_o
);

  // Compute the register value after one step and the bit leaving it.
  always_comb begin
    q_o     = q_i;
    expel_o = 1'b0;
    case (mode_i)
      MODE_SHL: begin
        q_o     = {q_i[WIDTH-2:0], sin_i};
        expel_o = q_i[WIDTH-1];
      end
      MODE_SHR: begin
        q_o     = {sin_i, q_i[WIDTH-1:1]};
        expel_o = q_i[0];
      end
      MODE_ROTL: begin
        q_o     = {q_i[WIDTH-2:0], q_i[WIDTH-1]};
        expel_o = q_i[WIDTH-1];
      end
      MODE_ROTR: begin
        q_o     = {q_i[0], q_i[WIDTH-1:1]};
        expel_o = q_i[0];
      end
      default: begin
        q_o     = q_i;
        expel_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/shift_reg_seq.sv
// Shift register with a direct single-cycle operation path and a
// multi-cycle sequencer that performs AMT single-bit steps of a latched
// shift/rotate mode. One shared shift_step instance serves both paths.
module shift_reg_seq
  import shift_reg_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int AMT_W = $clog2(WIDTH) + 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic [2:0]       MODE,
  input  logic             START,
  input  logic [AMT_W-1:0] AMT,
  input  logic             SIN,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             SOUT,
  output logic             BUSY,
  output logic             DONE
);

  localparam logic [AMT_W-1:0] CNT_ONE  = AMT_W'(1);
  localparam logic [AMT_W-1:0] CNT_ZERO = '0;

  state_t           state_q;
  logic [AMT_W-1:0] cnt_q;
  logic [2:0]       mode_q;
  logic [WIDTH-1:0] q_q;
  logic             sout_q;
  logic             busy_q;
  logic             done_q;

  logic [2:0]       step_mode;
  logic [WIDTH-1:0] step_q;
  logic             step_expel;
  logic             accept;

  // While running, the shifter follows the latched mode; otherwise the live MODE.
  assign step_mode = (state_q == RUN) ? mode_q : MODE;
  assign accept    = START && is_shift_mode(MODE);

  shift_step #(.WIDTH(WIDTH)) u_step (
    .q_i     (step_q_src()),
    .mode_i  (step_mode),
    .sin_i   (SIN),
    .q_o     (step_q),
    .expel_o (step_expel)
  );

  function automatic logic [WIDTH-1:0] step_q_src();
    return q_q;
  endfunction

  // FSM, down-counter and all registered outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= CNT_ZERO;
      mode_q  <= MODE_HOLD;
      q_q     <= '0;
      sout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            // Accepting edge only latches the request; Q is untouched.
            mode_q <= MODE;
            cnt_q  <= AMT;
            if (AMT == CNT_ZERO) begin
              done_q <= 1'b1;
            end else begin
              state_q <= RUN;
              busy_q  <= 1'b1;
            end
          end else if (EN) begin
            case (MODE)
              MODE_LOAD:  q_q <= D;
              MODE_CLEAR: q_q <= '0;
              MODE_SHL, MODE_SHR, MODE_ROTL, MODE_ROTR: begin
                q_q    <= step_q;
                sout_q <= step_expel;
              end
              default: q_q <= q_q;
            endcase
          end
        end
        RUN: begin
          q_q    <= step_q;
          sout_q <= step_expel;
          cnt_q  <= cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign Q    = q_q;
  assign SOUT = sout_q;
  assign BUSY = busy_q;
  assign DONE = done_q;

endmodule

// File: tb/tb_shift_reg_seq.sv
// Directed bench for shift_reg_seq (WIDTH=8). Each stimulus row drives the
// inputs for one clock edge and queues the expected post-edge outputs; a
// separate monitor pops and compares after every rising edge.
module tb_shift_reg_seq;

  localparam int WIDTH = 8;
  localparam int AMT_W = 4;

  logic             CLK = 1'b0;
  logic             RST = 1'b1;
  logic             EN = 1'b0;
  logic [2:0]       MODE = 3'b000;
  logic             START = 1'b0;
  logic [AMT_W-1:0] AMT = '0;
  logic             SIN = 1'b0;
  logic [WIDTH-1:0] D = '0;
  logic [WIDTH-1:0] Q;
  logic             SOUT;
  logic             BUSY;
  logic             DONE;

  typedef struct {
    logic [WIDTH-1:0] q;
    logic             s;
    logic             b;
    logic             d;
    int               id;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passes = 0;
  int   row_id = 0;

  shift_reg_seq #(.WIDTH(WIDTH), .AMT_W(AMT_W)) dut (
    .CLK   (CLK),
    .RST   (RST),
    .EN    (EN),
    .MODE  (MODE),
    .START (START),
    .AMT   (AMT),
    .SIN   (SIN),
    .D     (D),
    .Q     (Q),
    .SOUT  (SOUT),
    .BUSY  (BUSY),
    .DONE  (DONE)
  );

  always #5 CLK = ~CLK;

  task automatic check_bit(input string name, input int id, input logic act, input logic req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL row%0d %s: got %b expected %b", id, name, act, req);
  endtask

  // Monitor: compare outputs 2 time units after every rising edge.
  initial begin
    forever begin
      @(posedge CLK);
      #2;
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        checks++;
        if (Q === e.q) passes++;
        else $display("FAIL row%0d Q: got %h expected %h", e.id, Q, e.q);
        check_bit("SOUT", e.id, SOUT, e.s);
        check_bit("BUSY", e.id, BUSY, e.b);
        check_bit("DONE", e.id, DONE, e.d);
        $display("row%0d: Q=%h SOUT=%b BUSY=%b DONE=%b", e.id, Q, SOUT, BUSY, DONE);
      end
    end
  end

  // Drive one edge worth of inputs and queue the expected result of that edge.
  task automatic row(input logic rst, input logic en, input logic [2:0] mode,
                     input logic start, input logic [AMT_W-1:0] amt, input logic sin,
                     input logic [WIDTH-1:0] d,
                     input logic [WIDTH-1:0] eq, input logic es, input logic eb, input logic ed);
    exp_t e;
    @(negedge CLK);
    RST = rst; EN = en; MODE = mode; START = start; AMT = amt; SIN = sin; D = d;
    row_id++;
    e.q = eq; e.s = es; e.b = eb; e.d = ed; e.id = row_id;
    exp_q.push_back(e);
  endtask

  initial begin
    //  rst en mode    st amt sin d        Q      S     B     D
    // Reset priority over a load.
    row(1, 1, 3'b001, 0, 0, 0, 8'hA5,   8'h00, 0, 0, 0);
    // Direct load then direct shl.
    row(0, 1, 3'b001, 0, 0, 0, 8'h81,   8'h81, 0, 0, 0);
    row(0, 1, 3'b010, 0, 0, 0, 8'h00,   8'h02, 1, 0, 0);
    // Reload 81, rotl sequence of 3 with RUN-time inputs that must be ignored.
    row(0, 1, 3'b001, 0, 0, 0, 8'h81,   8'h81, 1, 0, 0);
    row(0, 0, 3'b100, 1, 3, 0, 8'h00,   8'h81, 1, 1, 0);
    row(0, 1, 3'b001, 1, 7, 1, 8'hFF,   8'h03, 1, 1, 0);
    row(0, 1, 3'b001, 0, 0, 1, 8'hFF,   8'h06, 0, 1, 0);
    row(0, 0, 3'b000, 0, 0, 0, 8'h00,   8'h0C, 0, 0, 1);
    row(0, 0, 3'b000, 0, 0, 0, 8'h00,   8'h0C, 0, 0, 0);
    // Zero-count accept: DONE pulse, no BUSY, Q unchanged.
    row(0, 0, 3'b011, 1, 0, 1, 8'h00,   8'h0C, 0, 0, 1);
    row(0, 0, 3'b000, 0, 0, 0, 8'h00,   8'h0C, 0, 0, 0);
    // Reset during the second step of a rotr-by-5 on F0.
    row(0, 1, 3'b001, 0, 0, 0, 8'hF0,   8'hF0, 0, 0, 0);
    row(0, 0, 3'b101, 1, 5, 0, 8'h00,   8'hF0, 0, 1, 0);
    row(0, 0, 3'b000, 0, 0, 0, 8'h00,   8'h78, 0, 1, 0);
    row(1, 0, 3'b000, 0, 0, 0, 8'h00,   8'h00, 0, 0, 0);
    row(0, 0, 3'b000, 0, 0, 0, 8'h00,   8'h00, 0, 0, 0);
    row(0, 0, 3'b000, 0, 0, 0, 8'h00,   8'h00, 0, 0, 0);
    // START with a non-shift mode falls through to the direct load.
    row(0, 1, 3'b001, 1, 3, 0, 8'h3C,   8'h3C, 0, 0, 0);
    // shl by 10 (> WIDTH) with SIN=1 fills the register with ones.
    row(0, 0, 3'b010, 1, 10, 1, 8'h00,  8'h3C, 0, 1, 0);
    row(0, 0, 3'b000, 0, 0, 1, 8'h00,   8'h79, 0, 1, 0);
    row(0, 0, 3'b000, 0, 0, 1, 8'h00,   8'hF3, 0, 1, 0);
    row(0, 0, 3'b000, 0, 0, 1, 8'h00,   8'hE7, 1, 1, 0);
    row(0, 0, 3'b000, 0, 0, 1, 8'h00,   8'hCF, 1, 1, 0);
    row(0, 0, 3'b000, 0, 0, 1, 8'h00,   8'h9F, 1, 1, 0);
    row(0, 0, 3'b000, 0, 0, 1, 8'h00,   8'h3F, 1, 1, 0);
    row(0, 0, 3'b000, 0, 0, 1, 8'h00,   8'h7F, 0, 1, 0);
    row(0, 0, 3'b000, 0, 0, 1, 8'h00,   8'hFF, 0, 1, 0);
    row(0, 0, 3'b000, 0, 0, 1, 8'h00,   8'hFF, 1, 1, 0);
    row(0, 0, 3'b000, 0, 0, 1, 8'h00,   8'hFF, 1, 0, 1);
    // Hold mode and clear leave SOUT alone.
    row(0, 1, 3'b111, 0, 0, 0, 8'h55,   8'hFF, 1, 0, 0);
    row(0, 1, 3'b110, 0, 0, 0, 8'h55,   8'h00, 1, 0, 0);
    // Direct shr of a loaded value: SIN into MSB, LSB expelled.
    row(0, 1, 3'b001, 0, 0, 0, 8'h02,   8'h02, 1, 0, 0);
    row(0, 1, 3'b011, 0, 0, 1, 8'h00,   8'h81, 0, 0, 0);
    row(0, 1, 3'b101, 0, 0, 0, 8'h00,   8'hC0, 1, 0, 0);

    // Let the monitor drain the queue, with a bounded wait.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge CLK);
    #3;
    if (exp_q.size() > 0) begin
      checks++;
      $display("FAIL drain: %0d rows left unchecked, expected 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
